// File: rtl/muller_c_array.sv
// rtl/muller_c_array.sv - Array of runtime-configurable C-element / RS latch channels
// with optional input synchroniser, toggle pulses and saturating toggle counters.
module muller_c_array #(
  parameter int   CHANNELS    = 4,
  parameter int   N_IN        = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        en,
  input  logic [CHANNELS*N_IN-1:0]    c_in,
  input  logic [CHANNELS-1:0]         s,
  input  logic [CHANNELS-1:0]         r,
  input  logic                        cnt_clr,
  output logic [CHANNELS-1:0]         q,
  output logic [CHANNELS-1:0]         changed,
  output logic [CHANNELS*CNT_W-1:0]   toggle_cnt
);

  localparam int IN_W = CHANNELS * (N_IN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IN_W-1:0]          w_raw;
  logic [IN_W-1:0]          w_sync;
  logic [CHANNELS*N_IN-1:0] w_c;
  logic [CHANNELS-1:0]      w_s;
  logic [CHANNELS-1:0]      w_r;
  logic [CHANNELS-1:0]      w_q_next;
  logic [CHANNELS-1:0]      r_q;
  logic [CHANNELS-1:0]      r_changed;

  assign w_raw = {r, s, c_in};

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign w_sync = w_raw;
    end else begin : g_sync
      logic [IN_W-1:0] r_pipe [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < SYNC_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_sync = r_pipe[SYNC_STAGES-1];
    end
  endgenerate

  assign w_c = w_sync[CHANNELS*N_IN-1:0];
  assign w_s = w_sync[CHANNELS*N_IN +: CHANNELS];
  assign w_r = w_sync[CHANNELS*(N_IN+1) +: CHANNELS];

  // Every mode evaluates against the current q, so a mode switch never re-initialises state.
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      for (int k = 0; k < CHANNELS; k++) begin
        case (mode)
          2'b00: begin
            if (&w_c[k*N_IN +: N_IN])       w_q_next[k] = 1'b1;
            else if (~|w_c[k*N_IN +: N_IN]) w_q_next[k] = 1'b0;
          end
          2'b01: begin
            if (w_s[k])      w_q_next[k] = 1'b1;
            else if (w_r[k]) w_q_next[k] = 1'b0;
          end
          2'b10: begin
            if (w_r[k])      w_q_next[k] = 1'b0;
            else if (w_s[k]) w_q_next[k] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= {CHANNELS{RESET_VAL}};
      r_changed <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      // A clear wins over a coincident toggle; that toggle is deliberately lost.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (cnt_clr) begin
          r_cnt <= '0;
        end else if ((w_q_next[k] != r_q[k]) && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign toggle_cnt[k*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign q       = r_q;
  assign changed = r_changed;

endmodule

// File: tb/tb_muller_c_array.sv
// tb/tb_muller_c_array.sv - Directed bench: synchronised 2-input/3-bit-counter instance
// plus a bypass 3-input instance.
module tb_muller_c_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        en;
  logic        cnt_clr;

  logic [7:0]  c_a;
  logic [3:0]  s_a, r_a, q_a, ch_a;
  logic [11:0] cnt_a;

  logic [11:0] c_b;
  logic [3:0]  s_b, r_b, q_b, ch_b;
  logic [31:0] cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muller_c_array #(.CHANNELS(4), .N_IN(2), .SYNC_STAGES(2), .CNT_W(3), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .c_in(c_a), .s(s_a), .r(r_a),
    .cnt_clr(cnt_clr), .q(q_a), .changed(ch_a), .toggle_cnt(cnt_a)
  );

  muller_c_array #(.CHANNELS(4), .N_IN(3), .SYNC_STAGES(0), .CNT_W(8), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .c_in(c_b), .s(s_b), .r(r_b),
    .cnt_clr(cnt_clr), .q(q_b), .changed(ch_b), .toggle_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; en = 1'b1; cnt_clr = 1'b0;
    c_a = '0; s_a = '0; r_a = '0; c_b = '0; s_b = '0; r_b = '0;
    step(2);
    chk("reset_q", {28'd0, q_a}, 32'h0);
    chk("reset_changed", {28'd0, ch_a}, 32'h0);
    chk("reset_cnt", {20'd0, cnt_a}, 32'h0);
    rst_n = 1'b1;
    step(1);

    // C-element on ch0
    c_a[1:0] = 2'b01;
    step(3);
    chk("c_mixed_hold", {31'd0, q_a[0]}, 32'd0);
    c_a[1:0] = 2'b11;
    step(2);
    chk("c_latency_early", {31'd0, q_a[0]}, 32'd0);
    step(1);
    chk("c_set_q", {31'd0, q_a[0]}, 32'd1);
    chk("c_set_changed", {28'd0, ch_a}, 32'h1);
    chk("c_set_cnt", {29'd0, cnt_a[2:0]}, 32'd1);
    step(1);
    chk("c_changed_pulse_end", {28'd0, ch_a}, 32'h0);
    c_a[1:0] = 2'b10;
    step(3);
    chk("c_mixed_hold1", {31'd0, q_a[0]}, 32'd1);
    chk("c_mixed_cnt", {29'd0, cnt_a[2:0]}, 32'd1);
    c_a[1:0] = 2'b00;
    step(3);
    chk("c_clear_q", {31'd0, q_a[0]}, 32'd0);
    chk("c_clear_cnt", {29'd0, cnt_a[2:0]}, 32'd2);

    // RS conflict on ch1
    mode = 2'b01; s_a[1] = 1'b1; r_a[1] = 1'b1;
    step(2);
    chk("rs_latency_early", {31'd0, q_a[1]}, 32'd0);
    step(1);
    chk("rs_setdom_q", {31'd0, q_a[1]}, 32'd1);
    chk("rs_setdom_changed", {28'd0, ch_a}, 32'h2);
    mode = 2'b10;
    step(1);
    chk("rs_rstdom_q", {31'd0, q_a[1]}, 32'd0);
    chk("rs_rstdom_changed", {28'd0, ch_a}, 32'h2);
    chk("rs_rstdom_cnt", {29'd0, cnt_a[5:3]}, 32'd2);
    mode = 2'b01;
    step(1);
    chk("rs_back_q", {31'd0, q_a[1]}, 32'd1);

    // Hold mode then enable freeze on ch1
    mode = 2'b11; s_a[1] = 1'b0; r_a[1] = 1'b1; c_a = 8'hFF;
    step(4);
    chk("hold_q", {28'd0, q_a}, 32'h2);
    chk("hold_changed", {28'd0, ch_a}, 32'h0);
    chk("hold_cnt", {29'd0, cnt_a[5:3]}, 32'd3);
    c_a = 8'h00; en = 1'b0; mode = 2'b01;
    step(4);
    chk("en0_q", {28'd0, q_a}, 32'h2);
    chk("en0_changed", {28'd0, ch_a}, 32'h0);
    chk("en0_cnt", {29'd0, cnt_a[5:3]}, 32'd3);
    en = 1'b1;
    step(1);
    chk("en1_q", {31'd0, q_a[1]}, 32'd0);
    chk("en1_cnt", {29'd0, cnt_a[5:3]}, 32'd4);

    // Saturation on ch2 (3-bit counter)
    for (int t = 1; t <= 10; t++) begin
      s_a[2] = t[0]; r_a[2] = ~t[0];
      step(3);
      chk($sformatf("sat_q_%0d", t), {31'd0, q_a[2]}, {31'd0, t[0]});
      chk($sformatf("sat_changed_%0d", t), {31'd0, ch_a[2]}, 32'd1);
      chk($sformatf("sat_cnt_%0d", t), {29'd0, cnt_a[8:6]}, (t < 7) ? t : 32'd7);
    end
    s_a[2] = 1'b1; r_a[2] = 1'b0;
    step(2);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_q_toggles", {31'd0, q_a[2]}, 32'd1);
    chk("clr_changed", {31'd0, ch_a[2]}, 32'd1);
    chk("clr_cnt", {20'd0, cnt_a}, 32'd0);
    step(1);
    chk("clr_cnt_stays", {29'd0, cnt_a[8:6]}, 32'd0);

    // Async reset with a pending set in the pipeline
    s_a[3] = 1'b1;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", {28'd0, q_a}, 32'h0);
    chk("arst_changed", {28'd0, ch_a}, 32'h0);
    chk("arst_cnt", {20'd0, cnt_a}, 32'h0);
    s_a = '0; r_a = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    step(4);
    chk("arst_no_pending_q", {28'd0, q_a}, 32'h0);
    chk("arst_no_pending_changed", {28'd0, ch_a}, 32'h0);

    // Bypass instance, 3-input C-element on ch3
    mode = 2'b00;
    c_b[11:9] = 3'b011;
    step(1);
    chk("byp_mixed", {31'd0, q_b[3]}, 32'd0);
    c_b[11:9] = 3'b111;
    step(1);
    chk("byp_set_q", {28'd0, q_b}, 32'h8);
    chk("byp_changed", {28'd0, ch_b}, 32'h8);
    chk("byp_cnt", {24'd0, cnt_b[31:24]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
